prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Byte-stream program loader that fills the RISC_MIPS instruction/data memory and then releases the CPU. It writes a program image from a host link into MEM, the job the bench currently does with hierarchical writes. It sits between a UART/debug byte source and the memory write port. It holds the CPU in reset until a complete, checksum-valid image has been written.

Parameters:
ADDR_W, 10, memory word-address width; memory depth is 2^ADDR_W words.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
CLK1  in  1  sole clock, rising edge.
RST_N  in  1  synchronous active-low reset.
IN_DATA  in  8  byte from host link.
IN_VALID  in  1  IN_DATA valid.
IN_READY  out  1  loader can accept a byte; transfer happens when IN_VALID && IN_READY at a CLK1 edge.
MEM_WE  out  1  one-cycle memory write strobe.
MEM_ADDR  out  ADDR_W  word address for the write.
MEM_WDATA  out  32  word to write.
CPU_RST  out  1  high holds the CPU in reset.
DONE  out  1  image loaded and verified (sticky).
ERR  out  1  framing or checksum error (sticky).

Behaviour:
- Reset values (RST_N low at an edge): IN_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CPU_RST=1, DONE=0, ERR=0, state=IDLE. Byte counter, word counter, checksum and shift register are all cleared.
- Reset mid-frame aborts the load; the partially written memory is not cleared.
- Frame format: SYNC_BYTE, N[15:8], N[7:0], then N words of 4 bytes each, big-endian (MSB first), then CHK. CHK = XOR of all 4N payload bytes. Header bytes are excluded from CHK.
- States:
  - IDLE: IN_READY=1. A non-sync byte is discarded and the state stays IDLE. A SYNC_BYTE moves to CNT_H.
  - CNT_H: IN_READY=1; the accepted byte goes to N[15:8]. Next state CNT_L.
  - CNT_L: IN_READY=1; the accepted byte goes to N[7:0]. If the resulting N==0 or N>2^ADDR_W, next state is ERR; otherwise DATA.
  - DATA: IN_READY=1. Each accepted byte shifts into the word register and XORs into the checksum.
    - After the 4th byte of a word, next state is WR.
  - WR: lasts exactly one cycle. MEM_WE=1, MEM_ADDR=word counter, MEM_WDATA=assembled word, IN_READY=0.
    - Then the word counter increments. If the counter equals N, next state is CHK; otherwise DATA.
  - CHK: IN_READY=1. If the accepted byte equals the running checksum, next state is DONE; otherwise ERR.
  - DONE: IN_READY=0, DONE=1, CPU_RST=0. Sticky until RST_N.
  - ERR: IN_READY=0, ERR=1, CPU_RST=1. Sticky until RST_N.
- Latency and timing:
  - 4th byte accepted at edge k: MEM_WE is high during the cycle after edge k, and the write commits at edge k+1.
  - Checksum byte accepted at edge k: DONE rises and CPU_RST falls at edge k.
- Word addresses start at 0 and increment by 1. They never wrap, because N≤2^ADDR_W is enforced. With N=2^ADDR_W the final write goes to address 2^ADDR_W−1.
- MEM_WE is never high outside WR. MEM_ADDR and MEM_WDATA hold their last written values between writes.
- Between bytes, IN_VALID may drop for any number of cycles; the state, counters and checksum hold unchanged.
- IN_DATA is ignored whenever IN_READY=0, including in WR, DONE and ERR.
- A SYNC_BYTE value arriving inside the payload is treated as ordinary data; there is no resynchronisation.
- CPU_RST stays 1 in every state except DONE.

Test Plan:
- Frame A5 00 02 11 22 33 44 AA BB CC DD 44 with IN_VALID held high: MEM_WE pulses twice, writing addr0=0x11223344 and addr1=0xAABBCCDD. DONE=1 and CPU_RST=0 after the CHK byte, ERR=0. Total 14 cycles from the first sync byte to DONE, counting both WR cycles.
- Same frame with CHK=0x45: both words are written, then ERR=1, CPU_RST=1, DONE=0, and IN_READY stays 0 afterwards.
- Header A5 00 00: ERR=1 after the count bytes and MEM_WE never pulses. Repeat with A5 04 01 (N=1025 at ADDR_W=10): ERR=1.
- Leading garbage 00 FF 13 before frame A: the garbage is discarded and the result is identical to the first test.
- Frame A with IN_VALID toggled randomly and 1–5 idle cycles between bytes: same memory contents and DONE. Also check that the byte offered during each WR cycle is not consumed (IN_READY=0).
- RST_N pulsed low for one cycle after the 6th byte, then the full frame A resent: outputs are at reset values after the pulse, the second load completes, DONE=1, and addr0/addr1 hold the expected words.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a framed image from a host byte link,
// writes it word by word into instruction/data memory, releases the CPU once verified.
module prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              CLK1,
  input  logic              RST_N,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  output logic              CPU_RST,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_H, S_CNT_L, S_DATA, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0]     DEPTH    = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WCNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [31:0]       shreg_q, shreg_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [15:0]       n_new;
  logic [ADDR_W:0]   wcnt_inc;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    chk_d    = chk_q;
    shreg_d  = shreg_q;
    xfer     = IN_VALID && in_ready_q;
    n_new    = {n_q[15:8], IN_DATA};
    wcnt_inc = wcnt_q + WCNT_ONE;

    case (state_q)
      S_IDLE: if (xfer && IN_DATA == SYNC_BYTE) begin
        state_d = S_CNT_H;
        n_d     = '0;
        wcnt_d  = '0;
        bcnt_d  = '0;
        chk_d   = '0;
      end
      S_CNT_H: if (xfer) begin
        n_d[15:8] = IN_DATA;
        state_d   = S_CNT_L;
      end
      S_CNT_L: if (xfer) begin
        n_d     = n_new;
        // An empty image or one larger than memory can never load correctly.
        state_d = (n_new == 16'd0 || {1'b0, n_new} > DEPTH) ? S_ERR : S_DATA;
      end
      S_DATA: if (xfer) begin
        shreg_d = {shreg_q[23:0], IN_DATA};
        chk_d   = chk_q ^ IN_DATA;
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = S_WR;
      end
      S_WR: begin
        wcnt_d  = wcnt_inc;
        state_d = (17'(wcnt_inc) == {1'b0, n_q}) ? S_CHK : S_DATA;
      end
      S_CHK: if (xfer) state_d = (IN_DATA == chk_q) ? S_DONE : S_ERR;
      default: state_d = state_q;
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_CNT_H) || (state_d == S_CNT_L) ||
                  (state_d == S_DATA) || (state_d == S_CHK);
    mem_we_d    = (state_d == S_WR);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == S_WR) begin
      mem_addr_d  = wcnt_q[ADDR_W-1:0];
      mem_wdata_d = shreg_d;
    end
    cpu_rst_d = (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge CLK1) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      chk_q       <= '0;
      shreg_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      chk_q       <= chk_d;
      shreg_q     <= shreg_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign CPU_RST   = cpu_rst_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as bytes are
// issued and a monitor branch pops them on every MEM_WE pulse.
module tb_prog_loader;

  localparam int ADDR_W = 10;

  logic              CLK1 = 1'b0;
  logic              RST_N = 1'b0;
  logic [7:0]        IN_DATA = 8'h00;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic              CPU_RST;
  logic              DONE;
  logic              ERR;

  prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .CLK1(CLK1), .RST_N(RST_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .CPU_RST(CPU_RST), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK1 = ~CLK1;

  int cyc = 0;
  always @(posedge CLK1) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int xfer_cyc;
  logic [41:0] sb[$];  // {addr, data}

  logic [7:0] frame_a [12] = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    for (int i = 0; i < gap; i++) begin
      IN_VALID = 1'b0;
      IN_DATA  = 8'($urandom);
      @(negedge CLK1);
    end
    IN_DATA  = b;
    IN_VALID = 1'b1;
    w = 0;
    while (!IN_READY && w < 40) begin
      @(negedge CLK1);
      w++;
    end
    if (!IN_READY) begin
      total++; bad++;
      $display("FAIL send_timeout actual=%0h required=ready", b);
    end
    xfer_cyc = cyc;
    @(negedge CLK1);
    IN_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] chk_b, input int maxgap, input int nbytes,
                            output int t_first, output int t_last);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = (i == 11) ? chk_b : frame_a[i];
      if (i == 6)  sb.push_back({10'd0, 32'h11223344});
      if (i == 10) sb.push_back({10'd1, 32'hAABBCCDD});
      send_byte(b, (maxgap == 0) ? 0 : $urandom_range(5, 1));
      if (i == 0) t_first = xfer_cyc;
      t_last = xfer_cyc;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK1);
    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    @(negedge CLK1);
    RST_N = 1'b1;
  endtask

  initial begin
    int t0, t1;
    logic rdy_seen;

    fork
      forever begin
        logic [41:0] e;
        @(negedge CLK1);
        if (MEM_WE) begin
          chk("wr_in_ready", {31'd0, IN_READY}, 32'd0);
          if (sb.size() == 0) begin
            chk("unexpected_we", {22'd0, MEM_ADDR}, 32'hFFFFFFFF);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", {22'd0, MEM_ADDR}, {22'd0, e[41:32]});
            chk("wr_data", MEM_WDATA, e[31:0]);
          end
        end
      end
    join_none

    // Reset values
    do_reset();
    chk("rst_ready", {31'd0, IN_READY}, 32'd0);
    chk("rst_we", {31'd0, MEM_WE}, 32'd0);
    chk("rst_addr", {22'd0, MEM_ADDR}, 32'd0);
    chk("rst_wdata", MEM_WDATA, 32'd0);
    chk("rst_cpu", {31'd0, CPU_RST}, 32'd1);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);

    // Frame A, back to back
    send_frame(8'h44, 0, 12, t0, t1);
    chk("a_latency", t1 - t0, 32'd13);
    chk("a_done", {31'd0, DONE}, 32'd1);
    chk("a_cpu", {31'd0, CPU_RST}, 32'd0);
    chk("a_err", {31'd0, ERR}, 32'd0);
    chk("a_ready", {31'd0, IN_READY}, 32'd0);
    chk("a_sb", sb.size(), 32'd0);

    // Bad checksum
    do_reset();
    send_frame(8'h45, 0, 12, t0, t1);
    chk("bc_err", {31'd0, ERR}, 32'd1);
    chk("bc_done", {31'd0, DONE}, 32'd0);
    chk("bc_cpu", {31'd0, CPU_RST}, 32'd1);
    chk("bc_sb", sb.size(), 32'd0);
    IN_DATA = 8'hA5; IN_VALID = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK1);
      rdy_seen |= IN_READY;
    end
    IN_VALID = 1'b0;
    chk("bc_ready_stuck", {31'd0, rdy_seen}, 32'd0);
    chk("bc_err_sticky", {31'd0, ERR}, 32'd1);

    // N = 0
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("n0_err", {31'd0, ERR}, 32'd1);
    chk("n0_cpu", {31'd0, CPU_RST}, 32'd1);

    // N = 1025 exceeds depth
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h01, 0);
    chk("nbig_err", {31'd0, ERR}, 32'd1);
    chk("nbig_done", {31'd0, DONE}, 32'd0);

    // Leading garbage
    do_reset();
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h13, 0);
    send_frame(8'h44, 0, 12, t0, t1);
    chk("g_latency", t1 - t0, 32'd13);
    chk("g_done", {31'd0, DONE}, 32'd1);
    chk("g_err", {31'd0, ERR}, 32'd0);
    chk("g_sb", sb.size(), 32'd0);

    // Random idle gaps
    do_reset();
    send_frame(8'h44, 5, 12, t0, t1);
    chk("gap_done", {31'd0, DONE}, 32'd1);
    chk("gap_cpu", {31'd0, CPU_RST}, 32'd0);
    chk("gap_sb", sb.size(), 32'd0);

    // Reset mid-frame, then full reload
    do_reset();
    send_frame(8'h44, 0, 6, t0, t1);
    do_reset();
    chk("mr_ready", {31'd0, IN_READY}, 32'd0);
    chk("mr_we", {31'd0, MEM_WE}, 32'd0);
    chk("mr_addr", {22'd0, MEM_ADDR}, 32'd0);
    chk("mr_wdata", MEM_WDATA, 32'd0);
    chk("mr_cpu", {31'd0, CPU_RST}, 32'd1);
    chk("mr_done", {31'd0, DONE}, 32'd0);
    chk("mr_err", {31'd0, ERR}, 32'd0);
    send_frame(8'h44, 0, 12, t0, t1);
    chk("mr2_done", {31'd0, DONE}, 32'd1);
    chk("mr2_err", {31'd0, ERR}, 32'd0);
    chk("mr2_sb", sb.size(), 32'd0);

    repeat (3) @(negedge CLK1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
